// File: rtl/fetch_stage_pkg.sv
// Shared fetch-path definitions: widths, reset/bubble constants, IF/ID payload.
package fetch_stage_pkg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_VECTOR = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000; // ANDEQ r0,r0,r0
    localparam logic [PC_W-1:0]    PC_INC       = 32'd4;
    // R15 as seen by decode: address of the decoding instruction + 8.
    localparam logic [PC_W-1:0]    PC8_OFS      = 32'd8;

    // IF/ID pipeline payload
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pcplus8;
        logic               valid;
    } ifid_t;

    // Force a redirect target onto a word boundary
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID register: flush beats stall, stall holds, otherwise capture the fetch.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP     = NOP_INSTR,
    parameter logic [PC_W-1:0]    RST_PC8 = RESET_VECTOR + PC8_OFS
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  stall,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    // Reset/flush insert a bubble; the bubble still carries the fetch-side R15 value
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '{instr: NOP, pcplus8: RST_PC8, valid: 1'b0};
        end else if (flush) begin
            q <= '{instr: NOP, pcplus8: d.pcplus8, valid: 1'b0};
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC redirect mux, and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_VECTOR = fetch_stage_pkg::RESET_VECTOR,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = fetch_stage_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               BranchTakenE,
    input  logic [PC_W-1:0]    ALUResultE,
    input  logic               PCSrcW,
    input  logic [PC_W-1:0]    ResultW,
    input  logic [INSTR_W-1:0] InstrF,
    output logic [PC_W-1:0]    PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCPlus8D,
    output logic               ValidD
);

    logic [PC_W-1:0] pcf_q;
    logic [PC_W-1:0] pc_next;
    ifid_t           ifid_d;
    ifid_t           ifid_q;

    // Next PC: E-stage branch beats W-stage PC write; either redirect overrides StallF
    always_comb begin
        pc_next = pcf_q + PC_INC;
        if (BranchTakenE)  pc_next = align_pc(ALUResultE);
        else if (PCSrcW)   pc_next = align_pc(ResultW);
        else if (StallF)   pc_next = pcf_q;
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) pcf_q <= RESET_VECTOR;
        else       pcf_q <= pc_next;
    end

    // Captured R15 is this fetch's address + 8 so decode sees PC_of_InstrD+8
    assign ifid_d = '{instr: InstrF, pcplus8: pcf_q + PC8_OFS, valid: 1'b1};

    if_id_reg #(
        .NOP     (NOP_INSTR),
        .RST_PC8 (RESET_VECTOR + PC8_OFS)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .stall (StallD),
        .flush (FlushD),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign PCF      = pcf_q;
    assign InstrD   = ifid_q.instr;
    assign PCPlus8D = ifid_q.pcplus8;
    assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle model compare plus literal pins.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW, InstrF;
    logic [31:0] PCF, InstrD, PCPlus8D;
    logic        ValidD;

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;

    // expected architectural state of the stage
    logic [31:0] m_pc, m_instr, m_pc8;
    logic        m_valid;

    always #5 clk = ~clk;

    // instruction memory: each word encodes its own address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hE000_0000 + a;
    endfunction

    assign InstrF = mem(PCF);

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
        .ResultW(ResultW), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD),
        .PCPlus8D(PCPlus8D), .ValidD(ValidD)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock with the given inputs; the model advances alongside the DUT
    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic br, input logic [31:0] alu,
                        input logic pw, input logic [31:0] rw);
        logic [31:0] tgt;
        reset = rst; StallF = sf; StallD = sd; FlushD = fd;
        BranchTakenE = br; ALUResultE = alu; PCSrcW = pw; ResultW = rw;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc8 = 32'h8; m_valid = 1'b0;
        end else begin
            if (br)      tgt = alu & ~32'h3;
            else if (pw) tgt = rw & ~32'h3;
            else if (sf) tgt = m_pc;
            else         tgt = m_pc + 32'd4;
            if (fd) begin
                m_instr = 32'h0; m_valid = 1'b0; m_pc8 = m_pc + 32'd8;
            end else if (!sd) begin
                m_instr = mem(m_pc); m_valid = 1'b1; m_pc8 = m_pc + 32'd8;
            end
            m_pc = tgt;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("PCF", PCF, m_pc);
            chk("InstrD", InstrD, m_instr);
            chk("PCPlus8D", PCPlus8D, m_pc8);
            chk("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        chk_en = 1'b1;
        chk("rst PCF", PCF, 32'h0);
        chk("rst InstrD", InstrD, 32'h0);
        chk("rst PCPlus8D", PCPlus8D, 32'h8);
        chk("rst ValidD", {31'b0, ValidD}, 32'h0);

        // 1: sequential fetch, one-cycle latency into D
        run(1);
        chk("seq PCF", PCF, 32'h4);
        chk("seq InstrD", InstrD, 32'hE000_0000);
        chk("seq PCPlus8D", PCPlus8D, 32'h8);
        chk("seq ValidD", {31'b0, ValidD}, 32'h1);
        run(1);
        chk("seq PCF2", PCF, 32'h8);

        // 2: stall F and D for two cycles at PCF=8
        step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        chk("stall PCF", PCF, 32'h8);
        chk("stall InstrD", InstrD, 32'hE000_0004);
        run(1);
        chk("release PCF", PCF, 32'hC);
        chk("release InstrD", InstrD, 32'hE000_0008);

        // 3: taken branch with flush of the wrong-path fetch
        step(0, 0, 0, 1, 1, 32'h40, 0, 32'h0);
        chk("br PCF", PCF, 32'h40);
        chk("br InstrD", InstrD, 32'h0);
        chk("br ValidD", {31'b0, ValidD}, 32'h0);
        run(1);
        chk("br next InstrD", InstrD, 32'hE000_0040);
        chk("br next PCPlus8D", PCPlus8D, 32'h48);

        // 4: branch beats PC write, both beat StallF
        step(0, 1, 0, 0, 1, 32'h40, 1, 32'h80);
        chk("prio PCF", PCF, 32'h40);

        // 5: flush beats stall; unaligned target is aligned
        run(2);
        step(0, 0, 1, 1, 1, 32'h43, 0, 32'h0);
        chk("flush+stall InstrD", InstrD, 32'h0);
        chk("flush+stall ValidD", {31'b0, ValidD}, 32'h0);
        chk("align PCF", PCF, 32'h40);

        // PC write from W alone, also aligned
        step(0, 0, 0, 0, 0, 32'h0, 1, 32'h0000_0123);
        chk("pcw PCF", PCF, 32'h120);

        // 6: wrap at top of address space
        step(0, 0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        chk("top PCF", PCF, 32'hFFFF_FFFC);
        run(1);
        chk("wrap PCF", PCF, 32'h0);
        chk("wrap InstrD", InstrD, 32'hDFFF_FFFC);
        chk("wrap PCPlus8D", PCPlus8D, 32'h4);

        // reset in the middle of a stall discards everything
        run(3);
        step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        chk("midrst PCF", PCF, 32'h0);
        chk("midrst ValidD", {31'b0, ValidD}, 32'h0);
        chk("midrst PCPlus8D", PCPlus8D, 32'h8);

        // mixed control vectors, model-checked every cycle
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 4) == 0), $urandom, 1'($urandom_range(0, 4) == 0), $urandom);

        @(posedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
